// File: rtl/bk_add_seq_pkg.sv
// Shared types and constants for the bk_add_seq wide add/subtract sequencer.
// SLICE_W is the width of the shared Brent-Kung slice adder.
package bk_add_seq_pkg;

  localparam int SLICE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The slice counter keeps at least one bit, even when there is only a single slice.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bk_slice_add16.sv
// 16-bit Brent-Kung parallel-prefix adder with carry-in and carry-out.
// The carry-in is folded into the bit-0 generate, so sum[0] = a0 ^ b0 ^ cin.
module bk_slice_add16 (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        carry_i,
  output logic [15:0] sum_o,
  output logic        carry_o
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] gg;
  logic [15:0] pp;

  always_comb begin
    g  = a_i & b_i;
    p  = a_i ^ b_i;
    gg = g;
    pp = p;
    gg[0] = g[0] | (p[0] & carry_i);
    // Up-sweep: build the group (g, p) terms at positions 1, 3, 7 and 15.
    for (int l = 0; l < 4; l++) begin
      for (int i = (2 << l) - 1; i < 16; i += (2 << l)) begin
        gg[4'(i)] = gg[4'(i)] | (pp[4'(i)] & gg[4'(i - (1 << l))]);
        pp[4'(i)] = pp[4'(i)] & pp[4'(i - (1 << l))];
      end
    end
    // Down-sweep: fill in the remaining prefix carries from the completed spans.
    for (int l = 2; l >= 0; l--) begin
      for (int i = (2 << l) + (1 << l) - 1; i < 16; i += (2 << l)) begin
        gg[4'(i)] = gg[4'(i)] | (pp[4'(i)] & gg[4'(i - (1 << l))]);
      end
    end
  end

  assign sum_o   = p ^ {gg[14:0], carry_i};
  assign carry_o = gg[15];

endmodule

// File: rtl/bk_add_seq.sv
// Multi-cycle WIDTH-bit add/subtract that drives one 16-bit Brent-Kung slice per cycle, LSB first.
// The optional signed-overflow output is enabled with the macro BK_ADD_SEQ_OVERFLOW_EN.
module bk_add_seq
  import bk_add_seq_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  input  logic             carry_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
`ifdef BK_ADD_SEQ_OVERFLOW_EN
  output logic             overflow_o,
`endif
  output logic             busy_o,
  output state_e           state_o
);

  localparam int N  = WIDTH / SLICE_W;
  localparam int KW = cnt_width(N);
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_width_chk
    $error("bk_add_seq: WIDTH must be a non-zero multiple of %0d", SLICE_W);
  end

  // Handshake: a request transfers on a rising edge where valid_i & ready_o; a result
  // transfers where valid_o & ready_i. ready_o and valid_o come from state alone.
  state_e state;
  state_e state_nx;

  logic [KW-1:0]      k;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_carry;
  logic               accept;

  assign accept = (state == IDLE) && valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (valid_i) state_nx = RUN;
      RUN:     if (k == K_LAST) state_nx = DONE;
      DONE:    if (ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Select the operand slice addressed by the counter.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int s = 0; s < N; s++) begin
      if (k == KW'(s)) begin
        slice_a = a_q[s*SLICE_W +: SLICE_W];
        slice_b = b_q[s*SLICE_W +: SLICE_W];
      end
    end
  end

  bk_slice_add16 u_slice (
    .a_i     (slice_a),
    .b_i     (slice_b),
    .carry_i (carry_q),
    .sum_o   (slice_sum),
    .carry_o (slice_carry)
  );

  // Subtraction is A + ~B + ~borrow, so B is stored inverted and the carry-in flipped.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      k       <= '0;
      a_q     <= a_i;
      b_q     <= sub_i ? ~b_i : b_i;
      sum_q   <= '0;
      carry_q <= carry_i ^ sub_i;
    end else if (state == RUN) begin
      for (int s = 0; s < N; s++) begin
        if (k == KW'(s)) sum_q[s*SLICE_W +: SLICE_W] <= slice_sum;
      end
      carry_q <= slice_carry;
      k       <= k + KW'(1);
    end
  end

`ifdef BK_ADD_SEQ_OVERFLOW_EN
  logic ovf_q;

  // Overflow uses the MSB-slice operand signs and result sign at the final slice write.
  always_ff @(posedge clk_i) begin
    if (rst_i || accept) begin
      ovf_q <= 1'b0;
    end else if ((state == RUN) && (k == K_LAST)) begin
      ovf_q <= (slice_a[SLICE_W-1] == slice_b[SLICE_W-1]) &&
               (slice_sum[SLICE_W-1] != slice_a[SLICE_W-1]);
    end
  end

  assign overflow_o = ovf_q;
`endif

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);
  assign busy_o  = (state != IDLE);
  assign sum_o   = sum_q;
  assign carry_o = carry_q;
  assign state_o = state;

endmodule

// File: tb/tb_bk_add_seq.sv
// Bench for bk_add_seq (WIDTH=64): directed cases, then randomized operations with backpressure.
// Results are checked against an integer model of A+B+cin / A-B-borrow.
module tb_bk_add_seq;
  import bk_add_seq_pkg::*;

  localparam int W = 64;
  localparam int N = W / 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         sub_i;
  logic         carry_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         carry_o;
  logic         overflow_o;
  logic         busy_o;
  state_e       state_o;

  logic [W+1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bk_add_seq #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .sub_i      (sub_i),
    .carry_i    (carry_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .sum_o      (sum_o),
    .carry_o    (carry_o),
`ifdef BK_ADD_SEQ_OVERFLOW_EN
    .overflow_o (overflow_o),
`endif
    .busy_o     (busy_o),
    .state_o    (state_o)
  );

`ifndef BK_ADD_SEQ_OVERFLOW_EN
  assign overflow_o = 1'b0;
`endif

  task automatic check(input string tag, input logic [W+1:0] got, input logic [W+1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {overflow, carry/no-borrow, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sub, input logic cin);
    logic [W:0] r;
    logic       c;
    logic       ovf;
    if (!sub) begin
      r   = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      c   = r[W];
      ovf = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    end else begin
      r   = {1'b0, a} - {1'b0, b} - (W+1)'(cin);
      c   = ~r[W];
      ovf = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
    end
    return {ovf, c, r[W-1:0]};
  endfunction

  function automatic logic [W-1:0] rand64();
    return {$urandom, $urandom};
  endfunction

  // Called at a negedge while IDLE; returns at the negedge after the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                      input logic cin);
    check("ready_idle", ready_o, 1'b1);
    a_i = a; b_i = b; sub_i = sub; carry_i = cin; valid_i = 1'b1;
    @(posedge clk);
    exp_q.push_back(model(a, b, sub, cin));
    @(negedge clk);
    valid_i = 1'b0;
    a_i = rand64(); b_i = rand64(); sub_i = 1'($urandom_range(0, 1));
    check("run_ready_busy", {ready_o, busy_o}, 2'b01);
  endtask

  task automatic receive(input int hold);
    logic [W+1:0] exp;
    int lat = 0;
    while (!valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, N);
    if (exp_q.size() == 0) begin
      check("queue_empty", 1'b1, 1'b0);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    for (int h = 0; h <= hold; h++) begin
      check("sum", sum_o, exp[W-1:0]);
      check("carry", carry_o, exp[W]);
`ifdef BK_ADD_SEQ_OVERFLOW_EN
      check("overflow", overflow_o, exp[W+1]);
`endif
      check("done_vrb", {valid_o, ready_o, busy_o}, 3'b101);
      if (h < hold) begin
        ready_i = 1'b0;
        valid_i = 1'($urandom_range(0, 1));
        a_i = rand64();
        @(negedge clk);
      end
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_i = 1'b0;
    check("post_hs_vrb", {valid_o, ready_o, busy_o}, 3'b010);
  endtask

  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                    input logic cin, input int hold);
    send(a, b, sub, cin);
    receive(hold);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    a_i = '0; b_i = '0; sub_i = 1'b0; carry_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_vrb", {valid_o, ready_o, busy_o}, 3'b010);
    check("rst_sum", sum_o, '0);
    check("rst_carry", carry_o, 1'b0);
    check("rst_ovf", overflow_o, 1'b0);
    check("rst_state", state_o, IDLE);

    // Directed cases.
    op(64'h0000_0000_0000_FFFF, 64'h0, 1'b0, 1'b1, 0);
    op(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    op(64'd5, 64'd7, 1'b1, 1'b0, 0);
    op(64'd7, 64'd5, 1'b1, 1'b0, 0);
    op(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0);
    op(64'h8000_0000_0000_0000, 64'h1, 1'b1, 1'b0, 3);
    op(64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b1, 1);

    // Reset after slice 1 of a RUN discards the operation.
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    check("midrst_vrb", {valid_o, ready_o, busy_o}, 3'b010);
    check("midrst_sum", sum_o, '0);
    check("midrst_carry", carry_o, 1'b0);
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("midrst_no_result", valid_o, 1'b0);
    end
    ready_i = 1'b0;
    op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1'b0, 0);

    // Randomized operations with corner-biased operands and random backpressure.
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      case ($urandom_range(0, 5))
        0:       a = '1;
        1:       a = 64'h7FFF_FFFF_FFFF_FFFF;
        2:       a = 64'h8000_0000_0000_0000;
        default: a = rand64();
      endcase
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = 64'h1;
        default: b = rand64();
      endcase
      op(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    check("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
